alu_ctrl: RTL and testbench

Sequencing controller directly upstream of the sequential ALU datapath. It accepts an operation request, captures operands and opcode, holds them stable, and drives the datapath's 5-bit Gray-coded state bus through the add/compare path or the 16-step multiply/divide path. It returns to the hold state so the datapath latches its result, then pulses `done` for one cycle.

---
 rtl/alu_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Sequencer for the ALU datapath: 17-cycle mul/div walk, 2-cycle add/cmp; start ignored while busy.
// Optional ALU_CTRL_DIV0_EN adds a divide-by-zero err flag captured on accept.
module alu_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [1:0]       opcode,
  output logic [4:0]       cstate,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [4:0] {
    S0  = 5'b00000, S1  = 5'b00001, S2  = 5'b00011, S3  = 5'b00010,
    S4  = 5'b00110, S5  = 5'b00111, S6  = 5'b00101, S7  = 5'b00100,
    S8  = 5'b01100, S9  = 5'b01101, S10 = 5'b01111, S11 = 5'b01110,
    S12 = 5'b01010, S13 = 5'b01011, S14 = 5'b01001, S15 = 5'b01000,
    S16 = 5'b11000, S20 = 5'b10001, S31 = 5'b10000
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       opc_q, opc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = (state_q == S20) && start;

  always_comb begin
    state_d = S0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    case (state_q)
      S0:  state_d = S20;
      S20: begin
        if (start) begin
          state_d = (op_in == 2'b01 || op_in == 2'b10) ? S1 : S31;
          opa_d   = a_in;
          opb_d   = b_in;
          opc_d   = op_in;
        end else begin
          state_d = S20;
        end
      end
      S1:  state_d = S2;
      S2:  state_d = S3;
      S3:  state_d = S4;
      S4:  state_d = S5;
      S5:  state_d = S6;
      S6:  state_d = S7;
      S7:  state_d = S8;
      S8:  state_d = S9;
      S9:  state_d = S10;
      S10: state_d = S11;
      S11: state_d = S12;
      S12: state_d = S13;
      S13: state_d = S14;
      S14: state_d = S15;
      S15: state_d = S16;
      S16: state_d = S20;
      S31: state_d = S20;
      default: state_d = S0;
    endcase
    // Outputs are registered from the next state so they line up with cstate.
    busy_d = !(state_d == S0 || state_d == S20);
    done_d = (state_q == S16) || (state_q == S31);
  end

`ifdef ALU_CTRL_DIV0_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) err_d = (op_in == 2'b10) && (b_in == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_CTRL_DIV0_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_CTRL_DIV0_EN
      err_q   <= err_d;
`endif
    end
  end

  assign cstate = state_q;
  assign opA    = opa_q;
  assign opB    = opb_q;
  assign opcode = opc_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef ALU_CTRL_DIV0_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl against a step-counter reference model.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] opA, opB;
  logic [1:0]  opcode;
  logic [4:0]  cstate;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;

  // Model: m_state 0 = reset state, 20 = idle, 1..16 = mul/div step, 31 = add/cmp step.
  int          m_state = 0;
  logic [15:0] m_opa = '0, m_opb = '0;
  logic [1:0]  m_opc = '0;
  logic        m_busy = 0, m_done = 0, m_err = 0;

  alu_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .nrst(nrst), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .opA(opA), .opB(opB), .opcode(opcode), .cstate(cstate), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Step k of the mul/div walk is the k-th Gray code.
  function automatic logic [4:0] code_of(input int s);
    if (s == 0)  return 5'b00000;
    if (s == 20) return 5'b10001;
    if (s == 31) return 5'b10000;
    return 5'(s ^ (s >> 1));
  endfunction

  function automatic logic [41:0] exp_vec();
    return {code_of(m_state), m_opa, m_opb, m_opc, m_busy, m_done, m_err};
  endfunction

  function automatic logic [41:0] act_vec();
    return {cstate, opA, opB, opcode, busy, done, err};
  endfunction

  task automatic model_step(input logic st, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic rn);
    int old;
    old = m_state;
    if (!rn) begin
      m_state = 0; m_opa = '0; m_opb = '0; m_opc = '0; m_done = 0; m_err = 0;
    end else begin
      m_done = (old == 16) || (old == 31);
      if (old == 0) m_state = 20;
      else if (old == 20) begin
        if (st) begin
          m_state = (op == 2'b01 || op == 2'b10) ? 1 : 31;
          m_opa = a; m_opb = b; m_opc = op;
`ifdef ALU_CTRL_DIV0_EN
          m_err = (op == 2'b10) && (b == 16'h0000);
`endif
        end
      end else if (old >= 1 && old <= 15) m_state = old + 1;
      else m_state = 20;
    end
    m_busy = !(m_state == 0 || m_state == 20);
  endtask

  task automatic cyc(input logic st, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic rn);
    start = st; op_in = op; a_in = a; b_in = b; nrst = rn;
    @(posedge clk);
    model_step(st, op, a, b, rn);
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 2'b00, 16'h0, 16'h0, 0);
    cyc(0, 2'b00, 16'h0, 16'h0, 0);
    total++;
    if (act_vec() !== 42'b0) begin
      bad++; $display("FAIL reset_state: got %h want 0", act_vec());
    end
    cyc(0, 2'b00, 16'h0, 16'h0, 1);
    total++;
    if (cstate !== 5'b10001) begin
      bad++; $display("FAIL reset_release: cstate=%b want 10001", cstate);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b00, 16'h0, 16'h0, 1);
      total++;
      if (act_vec() !== exp_vec() || done !== 1'b0) begin
        bad++; $display("FAIL idle[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int want_lat);
    int lat;
    cyc(1, op, a, b, 1);
    lat = 1;
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL %s_accept: got %h want %h", name, act_vec(), exp_vec());
    end
    while (done !== 1'b1 && lat < 40) begin
      cyc(0, 2'b00, 16'h0, 16'h0, 1);
      lat++;
      total++;
      if (act_vec() !== exp_vec() || opA !== a || opB !== b) begin
        bad++; $display("FAIL %s_walk[%0d]: got %h want %h", name, lat, act_vec(), exp_vec());
      end
    end
    total++;
    if (lat !== want_lat) begin
      bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
    end
    cyc(0, 2'b00, 16'h0, 16'h0, 1);
  endtask

  task automatic test_mul();
    run_op("mul", 2'b01, 16'd3, 16'd5, 17);
  endtask

  task automatic test_add();
    run_op("add", 2'b00, 16'd7, 16'hFFFE, 2);
  endtask

  task automatic test_ignore_and_rearm();
    int lat;
    cyc(1, 2'b01, 16'd1, 16'd2, 1);
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 2'b00, 16'h0, 16'h0, 1);
      lat++;
    end
    total++;
    if (cstate !== 5'b01100) begin
      bad++; $display("FAIL at_s8: cstate=%b want 01100", cstate);
    end
    while (done !== 1'b1 && lat < 40) begin
      cyc(1, 2'b00, 16'd9, 16'd4, 1);
      lat++;
      total++;
      if (opA !== 16'd1 || act_vec() !== exp_vec()) begin
        bad++; $display("FAIL ignore_busy: got %h want %h", act_vec(), exp_vec());
      end
    end
    total++;
    if (lat !== 17) begin
      bad++; $display("FAIL ignore_latency: got %0d want 17", lat);
    end
    cyc(1, 2'b00, 16'd9, 16'd4, 1);
    total++;
    if (cstate !== 5'b10000 || opA !== 16'd9 || busy !== 1'b1) begin
      bad++; $display("FAIL rearm_in_done: cstate=%b opA=%0d busy=%b want 10000/9/1", cstate, opA, busy);
    end
    cyc(0, 2'b00, 16'h0, 16'h0, 1);
    cyc(0, 2'b00, 16'h0, 16'h0, 1);
  endtask

  task automatic test_reset_mid();
    cyc(1, 2'b10, 16'd100, 16'd7, 1);
    for (int i = 0; i < 9; i++) cyc(0, 2'b00, 16'h0, 16'h0, 1);
    total++;
    if (cstate !== 5'b01111) begin
      bad++; $display("FAIL at_s10: cstate=%b want 01111", cstate);
    end
    cyc(0, 2'b00, 16'h0, 16'h0, 0);
    total++;
    if (act_vec() !== 42'b0) begin
      bad++; $display("FAIL mid_reset: got %h want 0", act_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b00, 16'h0, 16'h0, 1);
      total++;
      if (act_vec() !== exp_vec() || done !== 1'b0) begin
        bad++; $display("FAIL mid_reset_release[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_div0();
    logic want_err;
`ifdef ALU_CTRL_DIV0_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    run_op("div0", 2'b10, 16'd50, 16'd0, 17);
    total++;
    if (err !== want_err) begin
      bad++; $display("FAIL div0_err: got %b want %b", err, want_err);
    end
    run_op("add_after_div0", 2'b00, 16'd1, 16'd1, 2);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got %b want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      cyc(1, 2'($urandom_range(3)), 16'($urandom), ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom), 1);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(1), 2'($urandom_range(3)), 16'($urandom),
          ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom), ($urandom_range(63) != 0));
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mul();
    test_add();
    test_ignore_and_rearm();
    test_reset_mid();
    test_div0();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
